// File: rtl/segment_mem_access.sv
// Memory-stage access sequencer. Splits one scalar or R-lane vector
// load/store into single-lane beats on an N-bit ready-handshake port.
// Load lanes are gathered into ReadDataM, and the pipeline is held
// through StallM while beats are outstanding.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no access in flight; a legal request raises StallM
// ACCESS | one beat per mem_ready edge at base + k
// DONE   | single cycle: DoneM high, ReadDataM valid for MEM/WB
module segment_mem_access #(
    parameter int N = 8,
    parameter int R = 6,
    parameter int A = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReqM,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             VecM,
    input  logic [A-1:0]     AddrM,
    input  logic [R*N-1:0]   WriteDataM,
    input  logic [N-1:0]     mem_rdata,
    input  logic             mem_ready,
    output logic [A-1:0]     mem_addr,
    output logic [N-1:0]     mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    output logic [R*N-1:0]   ReadDataM,
    output logic             StallM,
    output logic             DoneM,
    output logic             AccessErrM
);

    localparam int KW = (R > 1) ? $clog2(R) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k;
    logic          op_wr;
    logic          vec_q;
    logic [A-1:0]  base_q;

    logic req_legal;
    logic req_err;
    logic last_beat;

    assign req_legal = MemReqM & (MemReadM ^ MemWriteM);
    assign req_err   = MemReqM & MemReadM & MemWriteM;
    assign last_beat = vec_q ? (k == KW'(R - 1)) : (k == '0);

    // Sequencer state, beat index and gathered load data; the pipeline
    // segments update on the falling edge, so this block does too.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            op_wr     <= 1'b0;
            vec_q     <= 1'b0;
            base_q    <= '0;
            ReadDataM <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_legal) begin
                        state  <= ACCESS;
                        k      <= '0;
                        op_wr  <= MemWriteM;
                        vec_q  <= VecM;
                        base_q <= AddrM;
                        if (MemReadM) begin
                            ReadDataM <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!op_wr) begin
                            ReadDataM[int'(k)*N +: N] <= mem_rdata;
                        end
                        if (last_beat) begin
                            state <= DONE;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beat strobes and pipeline handshakes; everything is forced low while
    // reset is asserted, including the stall a pending request would raise.
    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        StallM     = 1'b0;
        DoneM      = 1'b0;
        AccessErrM = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    StallM     = req_legal;
                    AccessErrM = req_err;
                end
                ACCESS: begin
                    StallM   = 1'b1;
                    mem_addr = base_q + A'(k);
                    mem_re   = !op_wr;
                    mem_we   = op_wr;
                    if (op_wr) begin
                        mem_wdata = WriteDataM[int'(k)*N +: N];
                    end
                end
                DONE: begin
                    DoneM = 1'b1;
                end
                default: begin
                    StallM = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segment_mem_access.sv
// Testbench for segment_mem_access: directed scenarios plus randomized
// loads/stores checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_segment_mem_access;

    localparam int N = 8;
    localparam int R = 6;
    localparam int A = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             MemReqM;
    logic             MemReadM;
    logic             MemWriteM;
    logic             VecM;
    logic [A-1:0]     AddrM;
    logic [R*N-1:0]   WriteDataM;
    logic [N-1:0]     mem_rdata;
    logic             mem_ready;
    logic [A-1:0]     mem_addr;
    logic [N-1:0]     mem_wdata;
    logic             mem_re;
    logic             mem_we;
    logic [R*N-1:0]   ReadDataM;
    logic             StallM;
    logic             DoneM;
    logic             AccessErrM;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [N-1:0]   mem_model [logic [A-1:0]];
    logic [R*N-1:0] exp_rd;

    always #5 clk = ~clk;

    segment_mem_access #(.N(N), .R(R), .A(A)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (MemReqM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .VecM       (VecM),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .DoneM      (DoneM),
        .AccessErrM (AccessErrM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [R*N-1:0] rnd_vec();
        return {16'($urandom), $urandom};
    endfunction

    function automatic logic [N-1:0] mem_rd(input logic [A-1:0] a);
        if (!mem_model.exists(a)) mem_model[a] = N'($urandom);
        return mem_model[a];
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        MemReqM    = 1'b0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        VecM       = 1'($urandom);
        AddrM      = $urandom;
        WriteDataM = rnd_vec();
        mem_ready  = 1'($urandom);
        mem_rdata  = N'($urandom);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".re"},    64'(mem_re), 64'(0));
        chk({tag, ".we"},    64'(mem_we), 64'(0));
        chk({tag, ".stall"}, 64'(StallM), 64'(0));
    endtask

    // One complete access: request cycle, every beat (with any not-ready
    // cycles), the DONE cycle and one idle cycle afterwards.
    task automatic run_txn(input string nm, input logic rd, input logic vec,
                           input logic [A-1:0] base, input logic [R*N-1:0] wdata,
                           input int hold_beat, input int hold_len, input bit rnd);
        int nb;
        int waits;
        int total_waits;
        int stall_obs;
        logic [A-1:0] a;
        nb          = vec ? R : 1;
        total_waits = 0;
        stall_obs   = 0;

        MemReqM    = 1'b1;
        MemReadM   = rd;
        MemWriteM  = !rd;
        VecM       = vec;
        AddrM      = base;
        WriteDataM = wdata;
        mem_ready  = 1'($urandom);
        mem_rdata  = N'($urandom);
        @(posedge clk);
        chk({nm, ".req.stall"}, 64'(StallM), 64'(1));
        chk({nm, ".req.re"},    64'(mem_re), 64'(0));
        chk({nm, ".req.we"},    64'(mem_we), 64'(0));
        chk({nm, ".req.rdata"}, 64'(ReadDataM), 64'(exp_rd));
        stall_obs += int'(StallM);
        next_cycle();
        if (rd) exp_rd = '0;

        for (int j = 0; j < nb; j++) begin
            a = base + A'(j);
            waits = (j == hold_beat) ? hold_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            total_waits += waits;
            for (int w = 0; w <= waits; w++) begin
                mem_ready = (w == waits);
                mem_rdata = mem_ready ? mem_rd(a) : N'($urandom);
                @(posedge clk);
                chk({nm, ".addr"},  64'(mem_addr), 64'(a));
                chk({nm, ".re"},    64'(mem_re), 64'(rd));
                chk({nm, ".we"},    64'(mem_we), 64'(!rd));
                if (!rd) chk({nm, ".wdata"}, 64'(mem_wdata), 64'(wdata[j*N +: N]));
                chk({nm, ".beat.rdata"}, 64'(ReadDataM), 64'(exp_rd));
                chk({nm, ".beat.done"},  64'(DoneM), 64'(0));
                stall_obs += int'(StallM);
                next_cycle();
            end
            if (rd) exp_rd[j*N +: N] = mem_model[a];
            else    mem_model[a] = wdata[j*N +: N];
        end

        mem_ready = 1'($urandom);
        mem_rdata = N'($urandom);
        @(posedge clk);
        chk({nm, ".done"},       64'(DoneM), 64'(1));
        chk_quiet({nm, ".donecyc"});
        chk({nm, ".done.rdata"}, 64'(ReadDataM), 64'(exp_rd));
        chk({nm, ".stallcnt"},   64'(stall_obs), 64'(nb + 1 + total_waits));
        next_cycle();

        drive_idle();
        @(posedge clk);
        chk({nm, ".post.done"},  64'(DoneM), 64'(0));
        chk_quiet({nm, ".post"});
        chk({nm, ".post.rdata"}, 64'(ReadDataM), 64'(exp_rd));
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [R*N-1:0] wd;
        logic           rd;
        logic           vec;
        logic [A-1:0]   base;

        exp_rd     = '0;
        reset      = 1'b0;
        MemReqM    = 1'b1;
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        VecM       = 1'b1;
        AddrM      = 32'h10;
        WriteDataM = rnd_vec();
        mem_rdata  = 8'h33;
        mem_ready  = 1'b1;
        @(posedge clk);
        chk("rst.addr",  64'(mem_addr), 64'(0));
        chk("rst.wdata", 64'(mem_wdata), 64'(0));
        chk("rst.rdata", 64'(ReadDataM), 64'(0));
        chk("rst.done",  64'(DoneM), 64'(0));
        chk("rst.err",   64'(AccessErrM), 64'(0));
        chk_quiet("rst");
        next_cycle();
        next_cycle();
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        chk_quiet("idle0");
        next_cycle();

        // T1: vector load 0x10..0x15 = 01..06, ready tied high
        for (int i = 0; i < R; i++) mem_model[32'h10 + A'(i)] = N'(i + 1);
        run_txn("T1", 1'b1, 1'b1, 32'h10, rnd_vec(), -1, 0, 1'b0);
        @(posedge clk);
        chk("T1.lanes", 64'(ReadDataM), 64'(48'h060504030201));
        next_cycle();

        // T2: vector store AA..AF at 0x20, ready low 2 cycles on beat 3
        run_txn("T2", 1'b0, 1'b1, 32'h20, 48'hAFAEADACABAA, 3, 2, 1'b0);
        @(posedge clk);
        chk("T2.rdata_kept", 64'(ReadDataM), 64'(48'h060504030201));
        next_cycle();

        // T3: scalar load from 0x7
        mem_model[32'h7] = 8'h5A;
        run_txn("T3", 1'b1, 1'b0, 32'h7, rnd_vec(), -1, 0, 1'b0);
        @(posedge clk);
        chk("T3.lanes", 64'(ReadDataM), 64'(48'h5A));
        next_cycle();

        // T4: vector load wrapping past the top of the address space
        run_txn("T4", 1'b1, 1'b1, 32'hFFFFFFFE, rnd_vec(), -1, 0, 1'b1);

        // T5: read and write together is an access error, no beats issued
        MemReqM   = 1'b1;
        MemReadM  = 1'b1;
        MemWriteM = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        chk("T5.err", 64'(AccessErrM), 64'(1));
        chk_quiet("T5.errcyc");
        next_cycle();
        drive_idle();
        @(posedge clk);
        chk("T5.err_pulse", 64'(AccessErrM), 64'(0));
        chk("T5.nodone",    64'(DoneM), 64'(0));
        chk_quiet("T5.after");
        next_cycle();

        // request with neither read nor write is ignored
        MemReqM   = 1'b1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        @(posedge clk);
        chk("nop.err", 64'(AccessErrM), 64'(0));
        chk_quiet("nop");
        next_cycle();
        @(posedge clk);
        chk_quiet("nop.held");
        next_cycle();
        drive_idle();

        // randomized loads and stores, partly near the wrap point
        for (int t = 0; t < 14; t++) begin
            rd  = 1'($urandom);
            vec = 1'($urandom);
            wd  = rnd_vec();
            if ($urandom_range(0, 3) == 0) base = 32'hFFFFFFFF - A'($urandom_range(0, 6));
            else                           base = A'($urandom_range(0, 40));
            run_txn($sformatf("rnd%0d", t), rd, vec, base, wd, -1, 0, 1'b1);
        end

        // T6: reset during beat 2 of a vector store
        run_txn("T6.pre", 1'b1, 1'b1, 32'h10, rnd_vec(), -1, 0, 1'b0);
        mem_model[32'h10] = 8'h11;
        run_txn("T6.pre2", 1'b1, 1'b0, 32'h10, rnd_vec(), -1, 0, 1'b0);
        wd         = rnd_vec();
        MemReqM    = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b1;
        VecM       = 1'b1;
        AddrM      = 32'h40;
        WriteDataM = wd;
        mem_ready  = 1'b1;
        @(posedge clk);
        next_cycle();
        @(posedge clk);
        next_cycle();
        @(posedge clk);
        next_cycle();
        @(posedge clk);
        chk("T6.beat2.we",   64'(mem_we), 64'(1));
        chk("T6.beat2.addr", 64'(mem_addr), 64'(32'h42));
        #2;
        reset = 1'b0;
        #1;
        chk("T6.rst.we",    64'(mem_we), 64'(0));
        chk("T6.rst.re",    64'(mem_re), 64'(0));
        chk("T6.rst.addr",  64'(mem_addr), 64'(0));
        chk("T6.rst.wdata", 64'(mem_wdata), 64'(0));
        chk("T6.rst.stall", 64'(StallM), 64'(0));
        chk("T6.rst.rdata", 64'(ReadDataM), 64'(0));
        next_cycle();
        @(posedge clk);
        chk("T6.rsthold.stall", 64'(StallM), 64'(0));
        chk("T6.rsthold.we",    64'(mem_we), 64'(0));
        next_cycle();
        reset  = 1'b1;
        exp_rd = '0;
        mem_model[32'h40] = wd[0 +: N];
        mem_model[32'h41] = wd[N +: N];
        drive_idle();
        @(posedge clk);
        chk("T6.idle.done", 64'(DoneM), 64'(0));
        chk_quiet("T6.idle");
        next_cycle();
        run_txn("T6.after", 1'b1, 1'b1, 32'h40, rnd_vec(), -1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
